// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: response owner, in-flight tag, latency bounds.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package mem_arb_pkg;

    // Who receives the read data when a tag reaches the pipe tail
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    // One in-flight access; valid = 0 marks a store, an idle cycle or a flushed fetch
    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;

    // Starvation counter width; the count saturates at all-ones
    localparam int                  STARVE_W   = 4;
    localparam logic [STARVE_W-1:0] STARVE_SAT = '1;

    // Drop a fetch tag when a flush is active; data tags pass untouched
    function automatic tag_t tag_scrub(tag_t t, logic flush);
        tag_t r;
        r = t;
        if (flush && (t.owner == OWN_IF)) begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Fixed-depth shift register of in-flight tags; flush invalidates every fetch-owned entry on the next edge.
// Latency: a tag pushed at edge k appears at o_tail exactly LAT cycles after its push cycle.
// Backpressure: none; shifts every cycle, one push per cycle (idle cycles push an invalid tag).
module mem_arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t i_push,
    input  logic i_flush,
    output tag_t o_tail
);

    tag_t r_pipe [LAT];

    // Shift tags toward the tail, scrubbing fetch tags (including the incoming one) on flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) begin
                r_pipe[k] <= '0;
            end
        end else begin
            r_pipe[0] <= tag_scrub(i_push, i_flush);
            for (int k = 1; k < LAT; k++) begin
                r_pipe[k] <= tag_scrub(r_pipe[k-1], i_flush);
            end
        end
    end

    assign o_tail = r_pipe[LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for IF fetch and MEM load/store; data wins by default. Optional macro MEM_ARB_STARVE_GUARD_EN forces fetch through after STARVE_MAX data grants.
// Latency: grant/stall/m_* combinational in the request cycle; read data returns MEM_LAT cycles after the grant.
// Backpressure: the losing port sees gnt = 0 and its stall output high and must hold its request.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        stall_if,
    output logic        stall_mem
);

    // Out-of-range latencies are clamped so the tag pipe always has a legal depth
    localparam int LAT = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                         (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;

    logic w_force_if;
    logic w_if_win;
    logic w_d_win;
    logic w_store;
    tag_t w_push;
    tag_t w_tail;

    // Data belongs to the older instruction, so it wins unless the guard forces fetch through
    assign w_if_win = !reset && if_req && (!d_req || w_force_if);
    assign w_d_win  = !reset && d_req && !w_if_win;
    assign w_store  = w_d_win && d_we;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_MAX[STARVE_W-1:0];

    logic [STARVE_W-1:0] r_starve;

    // Count data grants that leave a fetch waiting; clear when fetch is served or not requesting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (!if_req || w_if_win) begin
            r_starve <= '0;
        end else if (w_d_win && (r_starve != STARVE_SAT)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    assign w_force_if = (r_starve == STARVE_LIM);
`else
    // Strict data priority: fetch is never forced through and STARVE_MAX has no effect
    logic w_unused_starve;
    assign w_unused_starve = (STARVE_MAX != 0);
    assign w_force_if      = 1'b0;
`endif

    assign if_gnt    = w_if_win;
    assign d_gnt     = w_d_win;
    assign stall_if  = !reset && if_req && !w_if_win;
    assign stall_mem = !reset && d_req && !w_d_win;

    // Winner drives the memory port; an idle port is held at all-zero
    assign m_req   = w_if_win || w_d_win;
    assign m_we    = w_store;
    assign m_addr  = w_d_win ? d_addr : (w_if_win ? if_addr : 32'h0);
    assign m_wdata = w_store ? d_wdata : 32'h0;

    // Every cycle pushes a tag; only reads carry valid = 1
    assign w_push.valid = w_if_win || (w_d_win && !d_we);
    assign w_push.owner = w_d_win ? OWN_D : OWN_IF;

    mem_arb_tag_pipe #(
        .LAT (LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_flush (if_flush),
        .o_tail  (w_tail)
    );

    // The tail tag steers m_rdata to exactly one owner; the other rdata stays 0
    assign if_rvalid = !reset && w_tail.valid && (w_tail.owner == OWN_IF);
    assign d_rvalid  = !reset && w_tail.valid && (w_tail.owner == OWN_D);
    assign if_rdata  = if_rvalid ? m_rdata : 32'h0;
    assign d_rdata   = d_rvalid  ? m_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int SMAX = 4;
    localparam int NMAX = 4096;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] m_rdata;
    int          cyc = 0;

    // Memory read data per cycle (random, with directed overrides)
    logic [31:0] rd_tab [NMAX];
    assign m_rdata = rd_tab[cyc];

    // Two instances: latency 1 and latency 2, driven by identical stimulus
    logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_m_req, a_m_we, a_stall_if, a_stall_mem;
    logic [31:0] a_if_rdata, a_d_rdata, a_m_addr, a_m_wdata;
    logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_m_req, b_m_we, b_stall_if, b_stall_mem;
    logic [31:0] b_if_rdata, b_d_rdata, b_m_addr, b_m_wdata;

    mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .m_req(a_m_req), .m_we(a_m_we), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
        .m_rdata(m_rdata), .stall_if(a_stall_if), .stall_mem(a_stall_mem)
    );

    mem_arbiter #(.MEM_LAT(2), .STARVE_MAX(SMAX)) u_dut2 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .m_req(b_m_req), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
        .m_rdata(m_rdata), .stall_if(b_stall_if), .stall_mem(b_stall_mem)
    );

    always #5 clk = ~clk;

    // Reference model: per-latency schedule of expected responses by cycle, plus a starvation count
    bit   exp_ifv [2][NMAX];
    bit   exp_dv  [2][NMAX];
    int   cnt = 0;
    int   n_chk = 0;
    int   n_err = 0;
    logic obs_stall_if;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_dut(input string who, input int li,
                             input bit eifg, input bit edg, input logic [31:0] ea,
                             input bit ewe, input bit chk_wd, input logic [31:0] ewd,
                             input logic ifg, input logic dg, input logic sif, input logic sm,
                             input logic mreq, input logic mwe,
                             input logic [31:0] maddr, input logic [31:0] mwdata,
                             input logic ifv, input logic [31:0] ifd,
                             input logic dv, input logic [31:0] dd);
        bit eifv, edv;
        eifv = !reset && exp_ifv[li][cyc];
        edv  = !reset && exp_dv[li][cyc];
        chk({who, ".if_gnt"},    {31'b0, ifg},  {31'b0, eifg});
        chk({who, ".d_gnt"},     {31'b0, dg},   {31'b0, edg});
        chk({who, ".stall_if"},  {31'b0, sif},  {31'b0, !reset && if_req && !eifg});
        chk({who, ".stall_mem"}, {31'b0, sm},   {31'b0, !reset && d_req && !edg});
        chk({who, ".m_req"},     {31'b0, mreq}, {31'b0, eifg || edg});
        chk({who, ".m_we"},      {31'b0, mwe},  {31'b0, ewe});
        chk({who, ".m_addr"},    maddr, ea);
        if (chk_wd) chk({who, ".m_wdata"}, mwdata, ewd);
        chk({who, ".if_rvalid"}, {31'b0, ifv},  {31'b0, eifv});
        chk({who, ".if_rdata"},  ifd, eifv ? rd_tab[cyc] : 32'h0);
        chk({who, ".d_rvalid"},  {31'b0, dv},   {31'b0, edv});
        chk({who, ".d_rdata"},   dd,  edv ? rd_tab[cyc] : 32'h0);
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model, then move past the edge
    task automatic step();
        bit ifw, dw, st, idle;
        logic [31:0] ea, ewd;
        @(negedge clk);
        ifw = 1'b0;
        dw  = 1'b0;
        if (reset) begin
            for (int l = 0; l < 2; l++)
                for (int t = cyc; t < cyc + 6 && t < NMAX; t++) begin
                    exp_ifv[l][t] = 1'b0;
                    exp_dv[l][t]  = 1'b0;
                end
        end else begin
            ifw = if_req && (!d_req || (GUARD && cnt == SMAX));
            dw  = d_req && !ifw;
        end
        st   = dw && d_we;
        idle = !ifw && !dw;
        ea   = dw ? d_addr : (ifw ? if_addr : 32'h0);
        ewd  = st ? d_wdata : 32'h0;
        check_dut("L1", 0, ifw, dw, ea, st, st || idle, ewd,
                  a_if_gnt, a_d_gnt, a_stall_if, a_stall_mem, a_m_req, a_m_we, a_m_addr, a_m_wdata,
                  a_if_rvalid, a_if_rdata, a_d_rvalid, a_d_rdata);
        check_dut("L2", 1, ifw, dw, ea, st, st || idle, ewd,
                  b_if_gnt, b_d_gnt, b_stall_if, b_stall_mem, b_m_req, b_m_we, b_m_addr, b_m_wdata,
                  b_if_rvalid, b_if_rdata, b_d_rvalid, b_d_rdata);
        obs_stall_if = a_stall_if;
        if (!reset) begin
            for (int l = 0; l < 2; l++) begin
                if (ifw)             exp_ifv[l][cyc + l + 1] = 1'b1;
                if (dw && !d_we)     exp_dv[l][cyc + l + 1]  = 1'b1;
                if (if_flush)
                    for (int t = cyc + 1; t < cyc + 6; t++) exp_ifv[l][t] = 1'b0;
            end
        end
        if (reset || !if_req || ifw) cnt = 0;
        else if (dw && cnt < 15)     cnt = cnt + 1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input bit ir, input logic [31:0] ia, input bit fl,
                         input bit dr, input bit we, input logic [31:0] da, input logic [31:0] dwd);
        if_req   = ir;
        if_addr  = ia;
        if_flush = fl;
        d_req    = dr;
        d_we     = we;
        d_addr   = da;
        d_wdata  = dwd;
    endtask

    initial begin
        int tally;
        for (int i = 0; i < NMAX; i++) rd_tab[i] = $urandom;

        // Reset held with requests present: everything must read 0
        drive(1, 32'h4, 0, 1, 0, 32'h8, 32'h0);
        repeat (3) step();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) step();

        // Fetch only
        rd_tab[cyc + 1] = 32'hDEADBEEF;
        drive(1, 32'h10, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();

        // Continuous contention: loads and fetches every cycle
        tally = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1, $urandom, 0, 1, 0, $urandom, 0);
            step();
            tally += int'(obs_stall_if);
        end
        chk("contend_stall_if_count", tally, GUARD ? 16 : 20);
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (4) step();

        // Store
        drive(0, 0, 0, 1, 1, 32'h20, 32'h55);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();

        // Flush one cycle after a fetch grant, with a load in the flush cycle, then a normal fetch
        drive(1, 32'h40, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 1, 1, 0, 32'h80, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (4) step();
        drive(1, 32'h44, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (4) step();

        // Reset pulsed the cycle after a load grant
        drive(0, 0, 0, 1, 0, 32'h90, 0);
        step();
        reset = 1'b1;
        drive(1, 32'h50, 0, 1, 0, 32'h94, 0);
        step();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (5) step();

        // Randomized traffic with occasional flushes and resets
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, $urandom, $urandom);
            step();
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter sharing one unified instruction/data memory between the IF stage fetch port and the MEM stage load/store port of the 5-stage pipeline. It grants at most one access per cycle and tracks in-flight reads through a fixed-latency tag pipeline so each response is routed to its owner. It also drives stall requests back to the pipeline hazard logic. An optional starvation guard bounds how long fetch can be locked out by back-to-back data accesses.

## Interface
- MEM_LAT, 1 — fixed memory read latency in cycles, legal 1..4
- STARVE_MAX, 4 — maximum consecutive data grants while fetch is pending (guard build only), legal 1..15
- clk  in  1  — clock, rising edge
- reset  in  1  — asynchronous, active-high reset
- if_req  in  1  — fetch request, held until granted
- if_addr  in  32  — fetch byte address
- if_flush  in  1  — branch/jump flush; discard in-flight fetch responses
- if_gnt  out  1  — fetch accepted this cycle
- if_rvalid  out  1  — fetch data valid
- if_rdata  out  32  — fetch data
- d_req  in  1  — load/store request, held until granted
- d_we  in  1  — 1 = store, 0 = load
- d_addr  in  32  — data byte address
- d_wdata  in  32  — store data
- d_gnt  out  1  — data access accepted this cycle
- d_rvalid  out  1  — load data valid
- d_rdata  out  32  — load data
- m_req, m_we  out  1  — memory access strobe / write enable
- m_addr, m_wdata  out  32  — memory address / write data
- m_rdata  in  32  — memory read data, valid MEM_LAT cycles after the sampling edge
- stall_if, stall_mem  out  1  — stall requests: if_req && !if_gnt, d_req && !d_gnt

## Operation
- Arbitration is combinational each cycle. Winner drives m_* and gets gnt = 1. The loser's gnt = 0 and its stall output = 1.
- Default priority: data over fetch, because the data access belongs to the older instruction.
- No request: m_req = 0, and m_addr, m_wdata and m_we are driven to 0.
- Grant tag:
  - Every granted read pushes tag {valid = 1, owner = IF or D} into a MEM_LAT-deep shift register.
  - Stores and idle cycles push {valid = 0}.
- Response routing: at the tail of the pipeline, a valid tag raises exactly one of if_rvalid or d_rvalid. m_rdata passes through to the matching rdata output. The non-selected rdata output is 0.
- Flush: if_flush = 1 clears the valid bit of every IF-owned tag in the pipe on the next edge. Those fetches never raise if_rvalid. A fetch granted in the same cycle as if_flush is also discarded. D-owned tags are untouched.
- Stores complete at the sampling edge and never raise d_rvalid.
- Starvation counter (guard build):
  - Width 4 bits.
  - Increments on each data grant while if_req = 1.
  - Clears on any IF grant, or on any cycle with if_req = 0.
  - When count == STARVE_MAX and both ports request, IF wins.
  - Saturates and never wraps.

## Timing
- Throughput: one access per cycle, back-to-back with no bubbles.
- Read latency: grant in cycle n gives rvalid and rdata in cycle n + MEM_LAT, high for exactly one cycle.
- gnt and stall outputs are combinational from req and state; m_* is valid in the grant cycle.
- Reset behaviour:
  - While reset = 1, every output is 0, including the combinational gnt, stall and m_* outputs, which are gated by reset.
  - The tag pipe clears asynchronously and the starvation counter is 0.
  - Reset asserted mid-flight drops all pending responses; none appear after release.
- Simultaneous request and response: a response and a new grant in the same cycle are independent; both occur.
- if_flush together with an IF response tail in the same cycle: that response is still delivered. The flush acts on the pipe contents for the next edge only.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: the starvation counter is present and fetch is forced through after STARVE_MAX consecutive data grants.
- MEM_ARB_STARVE_GUARD_EN undefined: strict data priority. No counter is instantiated, fetch can be denied indefinitely, and STARVE_MAX is ignored.

## Structure
- Shared package mem_arb_pkg contains:
  - owner encoding: OWN_IF = 0, OWN_D = 1
  - tag struct {valid, owner}
  - MEM_LAT legal bounds
- One sub-module: mem_arb_tag_pipe. It is the MEM_LAT-deep tag shift register with asynchronous clear and a per-entry flush of IF-owned tags.
- The top level holds the arbitration logic, the starvation counter and the response muxing.

## Test plan
- Fetch only: if_req = 1, if_addr = 0x10, MEM_LAT = 1, m_rdata = 0xDEADBEEF. Required: if_gnt = 1 and m_addr = 0x10 in the same cycle; next cycle if_rvalid = 1 and if_rdata = 0xDEADBEEF.
- Contention with guard on, STARVE_MAX = 4, both requesting continuously. Required: grant sequence D, D, D, D, IF, repeating; stall_if high 4 of every 5 cycles.
- Contention with guard off. Required: d_gnt every cycle, if_gnt never, stall_if held at 1.
- Store: d_req = 1, d_we = 1, d_addr = 0x20, d_wdata = 0x55. Required: m_we = 1, m_addr = 0x20, m_wdata = 0x55 in the grant cycle; d_rvalid stays 0.
- Flush: MEM_LAT = 2, fetch granted in cycle n, if_flush = 1 in cycle n + 1. Required: no if_rvalid in cycle n + 2. A load interleaved in cycle n + 1 still returns in cycle n + 3. A later fetch returns normally.
- Reset mid-flight: load granted, reset pulsed in the next cycle. Required: all outputs 0 immediately, and no d_rvalid after reset release.
